// File: rtl/codec_config_sequencer_if.sv
// Bus between the codec configuration sequencer and the codec I2C register
// writer. The sequencer drives word/ignition/reset; the writer returns its
// finish flag and the three ACK bits of the transaction.
interface codec_config_sequencer_if;
    logic [15:0] i2c_word;
    logic        i2c_ignition;
    logic        i2c_rst_n;
    logic        i2c_finish;
    logic [2:0]  i2c_ack;

    modport master (
        output i2c_word, i2c_ignition, i2c_rst_n,
        input  i2c_finish, i2c_ack
    );

    modport slave (
        input  i2c_word, i2c_ignition, i2c_rst_n,
        output i2c_finish, i2c_ack
    );
endinterface

// File: rtl/codec_config_sequencer.sv
// Codec configuration sequencer: walks the fixed codec register table,
// drives the I2C writer one word per transaction, checks ACKs, retries
// failed words and reports done/error.
// Optional feature macro: CODEC_CFG_VOLUME_EN (runtime headphone volume,
// re-sends table entries 3 and 4 after bring-up).
module codec_config_sequencer #(
    parameter int unsigned NUM_WORDS      = 11,
    parameter int unsigned GAP_CYCLES     = 50000,
    parameter int unsigned STOP_HOLD      = 20000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    codec_config_sequencer_if.master  bus,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [3:0]                cfg_index,
    output logic [7:0]                fail_count
`ifdef CODEC_CFG_VOLUME_EN
    ,
    input  logic [6:0]                hp_vol,
    input  logic                      vol_update
`endif
);

    localparam int unsigned MAX_GH = (GAP_CYCLES > STOP_HOLD) ? GAP_CYCLES : STOP_HOLD;
    localparam int unsigned MAX_C  = (TIMEOUT_CYCLES > MAX_GH) ? TIMEOUT_CYCLES : MAX_GH;
    localparam int CNT_W = $clog2(MAX_C) + 1;
    localparam int RET_W = $clog2(MAX_RETRIES) + 1;

    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(STOP_HOLD - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RET_W-1:0] RET_LAST  = RET_W'(MAX_RETRIES - 1);
    localparam logic [3:0]       IDX_LAST  = 4'(NUM_WORDS - 1);
    localparam logic [3:0]       IDX_END   = 4'(NUM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE, S_GAP, S_SEND, S_HOLD, S_CHECK, S_FAIL, S_DONE, S_ERROR
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [RET_W-1:0]  retry;
    logic              fin_q;
    logic [2:0]        ack_q;
    logic [6:0]        vol_cur;
    logic              upd;      // running the volume-only pass (entries 3/4)

    // Register table; entries 3/4 carry the headphone volume field.
    function automatic logic [15:0] word_at(input logic [3:0] idx, input logic [6:0] vol);
        case (idx)
            4'd0:    word_at = 16'h1E00;
            4'd1:    word_at = 16'h0017;
            4'd2:    word_at = 16'h0217;
            4'd3:    word_at = {7'h02, 2'b00, vol};
            4'd4:    word_at = {7'h03, 2'b00, vol};
            4'd5:    word_at = 16'h0812;
            4'd6:    word_at = 16'h0A00;
            4'd7:    word_at = 16'h0C00;
            4'd8:    word_at = 16'h0E02;
            4'd9:    word_at = 16'h1000;
            4'd10:   word_at = 16'h1201;
            default: word_at = 16'h0000;
        endcase
    endfunction

`ifdef CODEC_CFG_VOLUME_EN
    logic [6:0] hp_vol_reg;
    logic       vol_pend;
    assign vol_cur = hp_vol_reg;
`else
    assign vol_cur = 7'h79;
`endif

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= S_IDLE;
            cnt              <= '0;
            retry            <= '0;
            fin_q            <= 1'b1;
            ack_q            <= 3'b000;
            upd              <= 1'b0;
            bus.i2c_word     <= 16'h1E00;
            bus.i2c_ignition <= 1'b0;
            bus.i2c_rst_n    <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
            cfg_index        <= 4'd0;
            fail_count       <= 8'd0;
`ifdef CODEC_CFG_VOLUME_EN
            hp_vol_reg       <= 7'h79;
            vol_pend         <= 1'b0;
`endif
        end else begin
            fin_q <= bus.i2c_finish;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state        <= S_GAP;
                        cnt          <= '0;
                        retry        <= '0;
                        upd          <= 1'b0;
                        cfg_index    <= 4'd0;
                        fail_count   <= 8'd0;
                        bus.i2c_word <= word_at(4'd0, vol_cur);
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
`ifdef CODEC_CFG_VOLUME_EN
                        vol_pend     <= 1'b0;
                    end else if (state == S_DONE && vol_pend) begin
                        // volume-only pass; done stays high throughout
                        state        <= S_GAP;
                        cnt          <= '0;
                        retry        <= '0;
                        upd          <= 1'b1;
                        vol_pend     <= 1'b0;
                        cfg_index    <= 4'd3;
                        bus.i2c_word <= word_at(4'd3, vol_cur);
                        busy         <= 1'b1;
`endif
                    end
                end
                S_GAP: begin
                    // a finish level left over from the last transaction must not look like an edge
                    fin_q <= 1'b1;
                    if (cnt == GAP_LAST) begin
                        state            <= S_SEND;
                        cnt              <= '0;
                        bus.i2c_rst_n    <= 1'b1;
                        bus.i2c_ignition <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SEND: begin
                    if (bus.i2c_finish && !fin_q) begin
                        state <= S_HOLD;
                        cnt   <= '0;
                    end else if (cnt == TO_LAST) begin
                        state            <= S_FAIL;
                        cnt              <= '0;
                        bus.i2c_rst_n    <= 1'b0;
                        bus.i2c_ignition <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state            <= S_CHECK;
                        cnt              <= '0;
                        ack_q            <= bus.i2c_ack;
                        bus.i2c_rst_n    <= 1'b0;
                        bus.i2c_ignition <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    cnt <= '0;
                    if (ack_q == 3'b111) begin
                        retry <= '0;
                        if (upd ? (cfg_index == 4'd4) : (cfg_index == IDX_LAST)) begin
                            state     <= S_DONE;
                            cfg_index <= IDX_END;
                            upd       <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            state        <= S_GAP;
                            cfg_index    <= cfg_index + 4'd1;
                            bus.i2c_word <= word_at(cfg_index + 4'd1, vol_cur);
                        end
                    end else begin
                        state <= S_FAIL;
                    end
                end
                S_FAIL: begin
                    cnt   <= '0;
                    retry <= retry + 1'b1;
                    if (fail_count != 8'hFF)
                        fail_count <= fail_count + 8'd1;
                    if (retry == RET_LAST) begin
                        state <= S_ERROR;
                        upd   <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                        error <= 1'b1;
                    end else begin
                        state <= S_GAP;
                    end
                end
                default: state <= S_IDLE;
            endcase
`ifdef CODEC_CFG_VOLUME_EN
            // latch always; only queue a re-send when the codec is or will be configured
            if (vol_update) begin
                hp_vol_reg <= hp_vol;
                if (state != S_IDLE && state != S_ERROR)
                    vol_pend <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Bench for codec_config_sequencer: behavioural I2C writer model plus a
// scoreboard of expected words, popped at each ignition rising edge.
module tb_codec_config_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       busy, done, error;
    logic [3:0] cfg_index;
    logic [7:0] fail_count;
`ifdef CODEC_CFG_VOLUME_EN
    logic [6:0] hp_vol;
    logic       vol_update;
`endif

    codec_config_sequencer_if bus();

    codec_config_sequencer #(
        .NUM_WORDS(11), .GAP_CYCLES(4), .STOP_HOLD(3),
        .TIMEOUT_CYCLES(200), .MAX_RETRIES(3)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus),
        .busy(busy), .done(done), .error(error),
        .cfg_index(cfg_index), .fail_count(fail_count)
`ifdef CODEC_CFG_VOLUME_EN
        , .hp_vol(hp_vol), .vol_update(vol_update)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [15:0] tbl [0:10] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                                16'h0812, 16'h0A00, 16'h0C00, 16'h0E02, 16'h1000, 16'h1201};
    logic [15:0] exp_q [$];

    task automatic push_range(input int a, input int b);
        for (int i = a; i <= b; i++) exp_q.push_back(tbl[i]);
    endtask

    // writer model: mode 0 ok, 1 nack once at fidx, 2 nack always at fidx, 3 no finish at fidx
    int   mode = 0;
    int   fidx = 0;
    bit   nack_used = 0;
    int   wcnt = 0;

    initial begin
        bus.i2c_finish = 1'b0;
        bus.i2c_ack    = 3'b000;
    end

    always @(negedge clk) begin
        if (!bus.i2c_rst_n) begin
            wcnt = 0;
            bus.i2c_finish = 1'b0;
            bus.i2c_ack    = 3'b000;
        end else if (bus.i2c_ignition) begin
            wcnt++;
            if (wcnt == 5 && !(mode == 3 && int'(cfg_index) == fidx)) begin
                bus.i2c_finish = 1'b1;
                bus.i2c_ack    = 3'b111;
                if (int'(cfg_index) == fidx) begin
                    if (mode == 2) bus.i2c_ack = 3'b011;
                    if (mode == 1 && !nack_used) begin
                        bus.i2c_ack = 3'b101;
                        nack_used = 1;
                    end
                end
            end
        end
    end

    // scoreboard: each new transaction must carry the next expected word
    logic prev_ign = 1'b0;
    always @(negedge clk) begin
        logic [15:0] w;
        if (bus.i2c_ignition && !prev_ign) begin
            w = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hDEAD;
            chk("word", {16'h0, bus.i2c_word}, {16'h0, w});
        end
        prev_ign = bus.i2c_ignition;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end();
        for (int n = 0; n < 5000 && !(done || error); n++) @(negedge clk);
        chk("end_reached", {31'h0, done | error}, 32'h1);
        repeat (2) @(negedge clk);
        chk("sb_left", exp_q.size(), 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_word"}, {16'h0, bus.i2c_word}, 32'h1E00);
        chk({tag, "_ign"},  {31'h0, bus.i2c_ignition}, 0);
        chk({tag, "_rstn"}, {31'h0, bus.i2c_rst_n}, 0);
        chk({tag, "_flags"}, {29'h0, busy, done, error}, 0);
        chk({tag, "_idx"},  {28'h0, cfg_index}, 0);
        chk({tag, "_fcnt"}, {24'h0, fail_count}, 0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
`ifdef CODEC_CFG_VOLUME_EN
        hp_vol = 7'h00;
        vol_update = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk_reset("rst");
        reset = 1'b1;
        @(negedge clk);

        // full table, second start mid-run must be ignored
        mode = 0; fidx = 0;
        push_range(0, 10);
        pulse_start();
        repeat (20) @(negedge clk);
        pulse_start();
        wait_end();
        chk("s1_done",  {31'h0, done}, 1);
        chk("s1_err",   {31'h0, error}, 0);
        chk("s1_busy",  {31'h0, busy}, 0);
        chk("s1_fcnt",  {24'h0, fail_count}, 0);
        chk("s1_idx",   {28'h0, cfg_index}, 11);

        // single NACK on index 5, word re-sent
        mode = 1; fidx = 5; nack_used = 0;
        push_range(0, 5); push_range(5, 10);
        pulse_start();
        wait_end();
        chk("s2_done",  {31'h0, done}, 1);
        chk("s2_err",   {31'h0, error}, 0);
        chk("s2_fcnt",  {24'h0, fail_count}, 1);

        // persistent NACK on index 5
        mode = 2; fidx = 5;
        push_range(0, 5); push_range(5, 5); push_range(5, 5);
        pulse_start();
        wait_end();
        chk("s3_err",   {31'h0, error}, 1);
        chk("s3_done",  {31'h0, done}, 0);
        chk("s3_idx",   {28'h0, cfg_index}, 5);
        chk("s3_fcnt",  {24'h0, fail_count}, 3);
        chk("s3_pins",  {30'h0, bus.i2c_ignition, bus.i2c_rst_n}, 0);

        // writer never finishes on index 2
        mode = 3; fidx = 2;
        push_range(0, 2); push_range(2, 2); push_range(2, 2);
        pulse_start();
        wait_end();
        chk("s4_err",   {31'h0, error}, 1);
        chk("s4_idx",   {28'h0, cfg_index}, 2);
        chk("s4_fcnt",  {24'h0, fail_count}, 3);
        chk("s4_busy",  {31'h0, busy}, 0);

        // reset pulse in the middle of the index-7 transaction
        mode = 0; fidx = 0;
        push_range(0, 7);
        pulse_start();
        for (int n = 0; n < 2000 && !(cfg_index == 4'd7 && bus.i2c_ignition); n++) @(negedge clk);
        chk("s5_reach7", {31'h0, bus.i2c_ignition}, 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk_reset("midrst");
        chk("s5_sb", exp_q.size(), 0);
        push_range(0, 10);
        pulse_start();
        wait_end();
        chk("s5_done",  {31'h0, done}, 1);
        chk("s5_fcnt",  {24'h0, fail_count}, 0);

`ifdef CODEC_CFG_VOLUME_EN
        // runtime volume change after bring-up
        exp_q.push_back(16'h0460);
        exp_q.push_back(16'h0660);
        hp_vol = 7'h60;
        vol_update = 1'b1;
        @(negedge clk);
        vol_update = 1'b0;
        for (int n = 0; n < 50 && !busy; n++) @(negedge clk);
        chk("v_busy",   {31'h0, busy}, 1);
        chk("v_done",   {31'h0, done}, 1);
        chk("v_idx",    {28'h0, cfg_index}, 3);
        for (int n = 0; n < 2000 && busy; n++) @(negedge clk);
        chk("v_idle",   {31'h0, busy}, 0);
        chk("v_done2",  {31'h0, done}, 1);
        repeat (2) @(negedge clk);
        chk("v_sb",     exp_q.size(), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
